// File: rtl/xlr_mem_arb.sv
// Two-requester (host / accelerator) arbiter for the banked accelerator memory port.
// Optional per-bank conflict counters are enabled with `define XLR_MEM_ARB_STATS_EN.
module xlr_mem_arb #(
    parameter  int NUM_MEMS           = 1,
    parameter  int LOG2_LINES_PER_MEM = 4,
    parameter  int LINE_W             = 256,
    localparam int BE_W               = LINE_W / 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_MEMS*LOG2_LINES_PER_MEM-1:0] h_mem_addr,
    input  logic [NUM_MEMS*LINE_W-1:0]             h_mem_wdata,
    input  logic [NUM_MEMS*BE_W-1:0]               h_mem_be,
    input  logic [NUM_MEMS-1:0]                    h_mem_rd,
    input  logic [NUM_MEMS-1:0]                    h_mem_wr,
    output logic [NUM_MEMS-1:0]                    h_mem_gnt,
    output logic [NUM_MEMS*LINE_W-1:0]             h_mem_rdata,
    output logic [NUM_MEMS-1:0]                    h_mem_rvalid,
    input  logic [NUM_MEMS*LOG2_LINES_PER_MEM-1:0] a_mem_addr,
    input  logic [NUM_MEMS*LINE_W-1:0]             a_mem_wdata,
    input  logic [NUM_MEMS*BE_W-1:0]               a_mem_be,
    input  logic [NUM_MEMS-1:0]                    a_mem_rd,
    input  logic [NUM_MEMS-1:0]                    a_mem_wr,
    output logic [NUM_MEMS-1:0]                    a_mem_gnt,
    output logic [NUM_MEMS*LINE_W-1:0]             a_mem_rdata,
    output logic [NUM_MEMS-1:0]                    a_mem_rvalid,
    output logic [NUM_MEMS*LOG2_LINES_PER_MEM-1:0] mem_addr,
    output logic [NUM_MEMS*LINE_W-1:0]             mem_wdata,
    output logic [NUM_MEMS*BE_W-1:0]               mem_be,
    output logic [NUM_MEMS-1:0]                    mem_rd,
    output logic [NUM_MEMS-1:0]                    mem_wr,
    input  logic [NUM_MEMS*LINE_W-1:0]             mem_rdata
`ifdef XLR_MEM_ARB_STATS_EN
    ,
    output logic [NUM_MEMS*16-1:0]                 conflict_cnt
`endif
);

    localparam int AW = LOG2_LINES_PER_MEM;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MEMS; gi++) begin : g_bank
            logic h_req, a_req, h_win, a_win;
            logic prio_q, prio_d;   // 0 favours host, 1 favours accelerator
            logic pend_q, pend_d;
            logic owner_q, owner_d; // 0 host, 1 accelerator

            assign h_req = h_mem_rd[gi] | h_mem_wr[gi];
            assign a_req = a_mem_rd[gi] | a_mem_wr[gi];

            // Reset gating here also zeroes the memory bus and grants during reset.
            assign h_win = rst_n & h_req & (~a_req | ~prio_q);
            assign a_win = rst_n & a_req & (~h_req |  prio_q);

            assign h_mem_gnt[gi] = h_win;
            assign a_mem_gnt[gi] = a_win;

            always_comb begin
                mem_addr[gi*AW +: AW]          = '0;
                mem_wdata[gi*LINE_W +: LINE_W] = '0;
                mem_be[gi*BE_W +: BE_W]        = '0;
                mem_rd[gi]                     = 1'b0;
                mem_wr[gi]                     = 1'b0;
                if (h_win) begin
                    mem_addr[gi*AW +: AW]          = h_mem_addr[gi*AW +: AW];
                    mem_wdata[gi*LINE_W +: LINE_W] = h_mem_wdata[gi*LINE_W +: LINE_W];
                    mem_be[gi*BE_W +: BE_W]        = h_mem_be[gi*BE_W +: BE_W];
                    mem_rd[gi]                     = h_mem_rd[gi];
                    mem_wr[gi]                     = h_mem_wr[gi];
                end else if (a_win) begin
                    mem_addr[gi*AW +: AW]          = a_mem_addr[gi*AW +: AW];
                    mem_wdata[gi*LINE_W +: LINE_W] = a_mem_wdata[gi*LINE_W +: LINE_W];
                    mem_be[gi*BE_W +: BE_W]        = a_mem_be[gi*BE_W +: BE_W];
                    mem_rd[gi]                     = a_mem_rd[gi];
                    mem_wr[gi]                     = a_mem_wr[gi];
                end
            end

            always_comb begin
                prio_d  = prio_q;
                if (h_win) begin
                    prio_d = 1'b1;
                end else if (a_win) begin
                    prio_d = 1'b0;
                end
                pend_d  = mem_rd[gi];
                owner_d = a_win;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    prio_q  <= 1'b0;
                    pend_q  <= 1'b0;
                    owner_q <= 1'b0;
                end else begin
                    prio_q  <= prio_d;
                    pend_q  <= pend_d;
                    owner_q <= owner_d;
                end
            end

            assign h_mem_rvalid[gi] = rst_n & pend_q & ~owner_q;
            assign a_mem_rvalid[gi] = rst_n & pend_q &  owner_q;
            assign h_mem_rdata[gi*LINE_W +: LINE_W] = owner_q ? '0 : mem_rdata[gi*LINE_W +: LINE_W];
            assign a_mem_rdata[gi*LINE_W +: LINE_W] = owner_q ? mem_rdata[gi*LINE_W +: LINE_W] : '0;

`ifdef XLR_MEM_ARB_STATS_EN
            logic [15:0] cnt_q, cnt_d;

            // Saturating count of cycles where both masters want this bank.
            always_comb begin
                cnt_d = cnt_q;
                if (h_req && a_req && (cnt_q != 16'hFFFF)) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= 16'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign conflict_cnt[gi*16 +: 16] = cnt_q;
`endif
        end
    endgenerate

endmodule
